// File: rtl/hack_cpu_sequencer.sv
// Multi-cycle control sequencer for the Hack CPU: fetches over a req/ack port,
// sequences data-memory read/write, and issues one-cycle datapath load strobes.
module hack_cpu_sequencer #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_run,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [15:0]       i_imem_rdata,
    output logic [15:0]       o_ir,
    input  logic              i_dec_memread,
    input  logic              i_dec_writeM,
    input  logic              i_dec_loadA,
    input  logic              i_dec_loadD,
    input  logic              i_jump_taken,
    input  logic [ADDR_W-1:0] i_a_reg,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    input  logic              i_dmem_ack,
    output logic              o_mdr_ld,
    output logic              o_ld_a,
    output logic              o_ld_d,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_instr_done,
    output logic [CNT_W-1:0]  o_retired,
    output logic              o_busy
);

    localparam int unsigned IR_W = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEMRD  = 3'd3,
        S_MEMWR  = 3'd4,
        S_EXEC   = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [IR_W-1:0]     r_ir;
    logic [CNT_W-1:0]    r_retired;
    logic [ADDR_W-1:0]   w_pc_next;

    logic w_imem_req;
    logic w_dmem_req;
    logic w_dmem_we;
    logic w_mdr_ld;
    logic w_ld_a;
    logic w_ld_d;
    logic w_instr_done;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; ir[15]=0 marks an A-instruction, which never touches memory
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_run) w_state_next = S_FETCH;
            end
            S_FETCH: begin
                if (i_imem_ack) w_state_next = S_DECODE;
            end
            S_DECODE: begin
                if (!r_ir[15])          w_state_next = S_EXEC;
                else if (i_dec_memread) w_state_next = S_MEMRD;
                else if (i_dec_writeM)  w_state_next = S_MEMWR;
                else                    w_state_next = S_EXEC;
            end
            S_MEMRD: begin
                if (i_dmem_ack) w_state_next = i_dec_writeM ? S_MEMWR : S_EXEC;
            end
            S_MEMWR: begin
                if (i_dmem_ack) w_state_next = S_EXEC;
            end
            S_EXEC: begin
                w_state_next = i_run ? S_FETCH : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output decode: requests follow state, strobes are single-cycle by construction
    always_comb begin
        w_imem_req   = 1'b0;
        w_dmem_req   = 1'b0;
        w_dmem_we    = 1'b0;
        w_mdr_ld     = 1'b0;
        w_ld_a       = 1'b0;
        w_ld_d       = 1'b0;
        w_instr_done = 1'b0;
        case (r_state)
            S_FETCH: w_imem_req = 1'b1;
            S_MEMRD: begin
                w_dmem_req = 1'b1;
                w_mdr_ld   = i_dmem_ack;
            end
            S_MEMWR: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = 1'b1;
            end
            S_EXEC: begin
                w_ld_a       = i_dec_loadA;
                w_ld_d       = i_dec_loadD & r_ir[15];
                w_instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_pc_next = (r_ir[15] & i_jump_taken) ? i_a_reg : r_pc + ADDR_W'(1);

    // Architectural registers: ir on fetch ack, pc and retire count on EXEC
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pc      <= '0;
            r_ir      <= '0;
            r_retired <= '0;
        end else begin
            if (r_state == S_FETCH && i_imem_ack) r_ir <= i_imem_rdata;
            if (r_state == S_EXEC) begin
                r_pc      <= w_pc_next;
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign o_imem_req   = w_imem_req;
    assign o_imem_addr  = r_pc;
    assign o_ir         = r_ir;
    assign o_dmem_req   = w_dmem_req;
    assign o_dmem_we    = w_dmem_we;
    assign o_mdr_ld     = w_mdr_ld;
    assign o_ld_a       = w_ld_a;
    assign o_ld_d       = w_ld_d;
    assign o_pc         = r_pc;
    assign o_instr_done = w_instr_done;
    assign o_retired    = r_retired;
    assign o_busy       = (r_state != S_IDLE);

endmodule
